// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter
//
// Shares one single-ported unified memory between the fetch stage and the memory stage
// of a pipelined MIPS core. Each port uses a level request held until a one-cycle ready
// pulse. The arbiter grants one port at a time and drives the memory through a req/ack
// handshake. It also produces the stall terms that the hazard unit ORs into StallF/StallD
// and into the M-stage hold.
//
// Ports
//   clk, reset             system clock, synchronous active-high reset
//   ireq/iaddr             fetch request and address (PCF)
//   irdata/iready          fetched instruction (InstrF) and completion pulse
//   dreq/dwe/daddr/dwdata  data request, store enable, address and store data
//   drdata/dready          load data (ReadDataM) and completion pulse
//   mem_req/mem_we         memory request (held until mem_ack) and write enable
//   mem_addr/mem_wdata     memory address and write data, registered at grant
//   mem_rdata/mem_ack      memory read data and one-cycle completion
//   stall_i/stall_d        request outstanding and not completing this cycle
//   busy                   a transaction is in flight
//
// Arbitration: data normally wins a tie with fetch. However, after STARVE_MAX
// consecutive data grants made while a fetch was waiting, the next grant goes to fetch.
// Every transaction returns to idle for one cycle, so the fastest rate is one access
// every two cycles.
module imem_dmem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CW         = 3   // 2**CW must exceed STARVE_MAX
) (
  input  logic        clk,
  input  logic        reset,
  // Fetch port
  input  logic        ireq,
  input  logic [31:0] iaddr,
  output logic [31:0] irdata,
  output logic        iready,
  // Data port
  input  logic        dreq,
  input  logic        dwe,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  output logic [31:0] drdata,
  output logic        dready,
  // Memory side
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  // Hazard / status
  output logic        stall_i,
  output logic        stall_d,
  output logic        busy
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIBusy = 2'd1,
    StDBusy = 2'd2
  } state_e;

  localparam logic [CW-1:0] StarveMax = CW'(STARVE_MAX);

  state_e        state;
  logic [CW-1:0] starve_cnt;

  logic grant_d;
  logic grant_i;

  // Grant decision; only acted on while idle.
  always_comb begin
    grant_d = dreq && (!ireq || (starve_cnt < StarveMax));
    grant_i = !grant_d && ireq;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      starve_cnt <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (grant_d) begin
            state     <= StDBusy;
            mem_req   <= 1'b1;
            mem_we    <= dwe;
            mem_addr  <= daddr;
            mem_wdata <= dwdata;
            // Count data grants only while a fetch is actually waiting.
            if (ireq) begin
              if (starve_cnt < StarveMax) starve_cnt <= starve_cnt + CW'(1);
            end else begin
              starve_cnt <= '0;
            end
          end else if (grant_i) begin
            state      <= StIBusy;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= iaddr;
            starve_cnt <= '0;
          end
        end
        StIBusy, StDBusy: begin
          if (mem_ack) begin
            state   <= StIdle;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: begin
          state   <= StIdle;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

  // Completion is combinational on mem_ack. An ack in a reset cycle belongs to an
  // abandoned transaction, so it must not produce a ready pulse.
  always_comb begin
    iready = (state == StIBusy) && mem_ack && !reset;
    dready = (state == StDBusy) && mem_ack && !reset;
  end

  // Read data is only meaningful alongside its ready pulse.
  assign irdata  = mem_rdata;
  assign drdata  = mem_rdata;

  assign stall_i = ireq && !iready;
  assign stall_d = dreq && !dready;
  assign busy    = (state != StIdle);

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter. Inputs are driven 1 time unit after the rising
// edge, and outputs are checked on the falling edge. "Cycle N" is the interval that
// starts at rising edge N of a scenario.
module tb_imem_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq, dreq, dwe, mem_ack;
  logic [31:0] iaddr, daddr, dwdata, mem_rdata;
  logic [31:0] irdata, drdata, mem_addr, mem_wdata;
  logic        iready, dready, mem_req, mem_we, stall_i, stall_d, busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(
    .STARVE_MAX (2),
    .CW         (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ireq      (ireq),
    .iaddr     (iaddr),
    .irdata    (irdata),
    .iready    (iready),
    .dreq      (dreq),
    .dwe       (dwe),
    .daddr     (daddr),
    .dwdata    (dwdata),
    .drdata    (drdata),
    .dready    (dready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall_i   (stall_i),
    .stall_d   (stall_d),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle; the caller drives inputs right after this returns.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Starvation sequence with STARVE_MAX=2: 1 means data, 0 means fetch.
  logic [5:0] order_d;
  logic [5:0] cnt_exp [6];

  initial begin
    reset = 1'b1; ireq = 0; dreq = 0; dwe = 0; mem_ack = 0;
    iaddr = 0; daddr = 0; dwdata = 0; mem_rdata = 0;
    order_d = 6'b011011;   // bit g is grant g: D D I D D I
    cnt_exp = '{32'd1, 32'd2, 32'd0, 32'd1, 32'd2, 32'd0};

    // ---- Reset state
    tick(); tick(); mid();
    chk("rst_mem_req",   32'(mem_req), 32'd0);
    chk("rst_mem_we",    32'(mem_we),  32'd0);
    chk("rst_mem_addr",  mem_addr,     32'd0);
    chk("rst_mem_wdata", mem_wdata,    32'd0);
    chk("rst_iready",    32'(iready),  32'd0);
    chk("rst_dready",    32'(dready),  32'd0);
    chk("rst_busy",      32'(busy),    32'd0);
    chk("rst_starve",    32'(dut.starve_cnt), 32'd0);

    // ---- Single fetch: request in cycle 0, ack in cycle 3
    tick(); reset = 0; ireq = 1; iaddr = 32'h40; mid();
    chk("f_c0_stall_i", 32'(stall_i), 32'd1);
    chk("f_c0_mem_req", 32'(mem_req), 32'd0);
    for (int c = 1; c <= 2; c++) begin
      tick(); mid();
      chk("f_busy_mem_req",  32'(mem_req), 32'd1);
      chk("f_busy_mem_addr", mem_addr,     32'h40);
      chk("f_busy_mem_we",   32'(mem_we),  32'd0);
      chk("f_busy_iready",   32'(iready),  32'd0);
      chk("f_busy_stall_i",  32'(stall_i), 32'd1);
    end
    tick(); mem_ack = 1; mem_rdata = 32'h20080005; mid();
    chk("f_c3_mem_req", 32'(mem_req), 32'd1);
    chk("f_c3_iready",  32'(iready),  32'd1);
    chk("f_c3_irdata",  irdata,       32'h20080005);
    chk("f_c3_stall_i", 32'(stall_i), 32'd0);
    chk("f_c3_dready",  32'(dready),  32'd0);
    tick(); mem_ack = 0; ireq = 0; mid();
    chk("f_c4_iready",  32'(iready),  32'd0);
    chk("f_c4_mem_req", 32'(mem_req), 32'd0);
    chk("f_c4_busy",    32'(busy),    32'd0);

    // ---- Simultaneous requests: data first, then fetch after an idle cycle
    tick(); ireq = 1; iaddr = 32'h44; dreq = 1; dwe = 0; daddr = 32'h100; mid();
    chk("s_c0_stall_d", 32'(stall_d), 32'd1);
    tick(); mid();
    chk("s_c1_mem_addr", mem_addr, 32'h100);
    chk("s_c1_mem_req",  32'(mem_req), 32'd1);
    tick(); mem_ack = 1; mem_rdata = 32'hDEAD0001; mid();
    chk("s_c2_dready",  32'(dready),  32'd1);
    chk("s_c2_drdata",  drdata,       32'hDEAD0001);
    chk("s_c2_iready",  32'(iready),  32'd0);
    chk("s_c2_stall_i", 32'(stall_i), 32'd1);
    tick(); mem_ack = 0; dreq = 0; mid();
    chk("s_c3_idle_req", 32'(mem_req), 32'd0);
    chk("s_c3_dready",   32'(dready),  32'd0);
    tick(); mid();
    chk("s_c4_mem_addr", mem_addr, 32'h44);
    chk("s_c4_mem_req",  32'(mem_req), 32'd1);
    tick(); mem_ack = 1; mem_rdata = 32'h8C090000; mid();
    chk("s_c5_iready", 32'(iready), 32'd1);
    chk("s_c5_irdata", irdata,      32'h8C090000);
    tick(); mem_ack = 0; ireq = 0; mid();
    chk("s_c6_starve", 32'(dut.starve_cnt), 32'd0);

    // ---- Starvation (STARVE_MAX=2): ireq held, dreq re-presented after each dready
    tick(); ireq = 1; iaddr = 32'h80; dreq = 1; dwe = 0; daddr = 32'h200; mid();
    for (int g = 0; g < 6; g++) begin
      chk("st_idle_busy", 32'(busy), 32'd0);
      tick(); mid();
      chk("st_grant_addr", mem_addr, order_d[g] ? 32'h200 : 32'h80);
      chk("st_starve_cnt", 32'(dut.starve_cnt), cnt_exp[g]);
      tick(); mem_ack = 1; mem_rdata = 32'(g); mid();
      chk("st_dready", 32'(dready), 32'(order_d[g]));
      chk("st_iready", 32'(iready), 32'(!order_d[g]));
      tick(); mem_ack = 0;
      if (g == 5) begin
        ireq = 0; dreq = 0;
      end
      mid();
    end
    chk("st_end_busy", 32'(busy), 32'd0);

    // ---- Store
    tick(); dreq = 1; dwe = 1; daddr = 32'h54; dwdata = 32'h7; mid();
    for (int c = 1; c <= 2; c++) begin
      tick(); mid();
      chk("w_mem_we",    32'(mem_we),  32'd1);
      chk("w_mem_addr",  mem_addr,     32'h54);
      chk("w_mem_wdata", mem_wdata,    32'h7);
      chk("w_mem_req",   32'(mem_req), 32'd1);
      chk("w_dready",    32'(dready),  32'd0);
    end
    tick(); mem_ack = 1; mid();
    chk("w_ack_dready", 32'(dready), 32'd1);
    tick(); mem_ack = 0; dreq = 0; dwe = 0; mid();
    chk("w_after_dready",  32'(dready),  32'd0);
    chk("w_after_mem_we",  32'(mem_we),  32'd0);
    chk("w_after_mem_req", 32'(mem_req), 32'd0);

    // ---- Reset mid-operation: reset in cycle 2 of the data access, ack in cycle 3
    tick(); dreq = 1; dwe = 0; daddr = 32'h300; mid();
    tick(); mid();
    chk("r_c1_busy", 32'(busy), 32'd1);
    tick(); reset = 1; mid();
    chk("r_c2_dready", 32'(dready), 32'd0);
    tick(); reset = 0; dreq = 0; mem_ack = 1; mem_rdata = 32'hBAD0BAD0; mid();
    chk("r_c3_mem_req", 32'(mem_req), 32'd0);
    chk("r_c3_dready",  32'(dready),  32'd0);
    chk("r_c3_busy",    32'(busy),    32'd0);
    tick(); mem_ack = 0; ireq = 1; iaddr = 32'h48; mid();
    tick(); mid();
    chk("r_f_mem_addr", mem_addr, 32'h48);
    chk("r_f_mem_req",  32'(mem_req), 32'd1);
    tick(); mem_ack = 1; mem_rdata = 32'h00001234; mid();
    chk("r_f_iready", 32'(iready), 32'd1);
    chk("r_f_irdata", irdata,      32'h00001234);
    tick(); mem_ack = 0; ireq = 0; mid();

    // ---- Spurious ack while idle
    tick(); mem_ack = 1; mem_rdata = 32'hFFFFFFFF; mid();
    chk("sp_iready", 32'(iready), 32'd0);
    chk("sp_dready", 32'(dready), 32'd0);
    chk("sp_busy",   32'(busy),   32'd0);
    tick(); mem_ack = 0; mid();
    chk("sp_next_busy",    32'(busy),    32'd0);
    chk("sp_next_mem_req", 32'(mem_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-ported unified memory between the pipelined MIPS processor's fetch stage (instruction port) and memory stage (data port).
- Arbitrates between the two ports and sequences each memory transaction with a req/ack handshake.
- Generates the stall signals that the hazard logic ORs into StallF/StallD and into the M-stage hold.
- Sits between the datapath's PCF/InstrF and ALUOutM/WriteDataM/ReadDataM nets and the external memory.

Parameters:
- STARVE_MAX, 4: maximum consecutive data grants allowed while a fetch is pending; the next grant then goes to fetch.
- CW, 3: width of the starvation counter; must satisfy 2^CW > STARVE_MAX.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ireq  in  1  fetch request; held until iready
- iaddr  in  32  fetch address (PCF)
- irdata  out  32  fetched instruction (InstrF)
- iready  out  1  one-cycle pulse: fetch complete
- dreq  in  1  data request; held until dready
- dwe  in  1  1 = store, 0 = load (MemWriteM)
- daddr  in  32  data address (ALUOutM)
- dwdata  in  32  store data (WriteDataM)
- drdata  out  32  load data (ReadDataM)
- dready  out  1  one-cycle pulse: data access complete
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid when mem_ack=1
- mem_ack  in  1  memory completion, one cycle
- stall_i  out  1  ireq & ~iready (combinational)
- stall_d  out  1  dreq & ~dready (combinational)
- busy  out  1  state != IDLE

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port named reset. All state updates on posedge clk.
- Reset values:
  - state = IDLE; mem_req = 0, mem_we = 0; mem_addr = 0, mem_wdata = 0.
  - iready = 0, dready = 0; starve_cnt = 0.
  - irdata and drdata are don't-care while their ready is 0.
- FSM states: IDLE, IBUSY, DBUSY.
- In IDLE, the grant is decided combinationally from the current inputs and registered at the edge:
  - Data wins if dreq=1 and (ireq=0 or starve_cnt < STARVE_MAX) → go to DBUSY.
  - Otherwise fetch wins if ireq=1 → go to IBUSY.
  - Otherwise stay in IDLE.
- On any grant, register the request into mem_addr/mem_we/mem_wdata and set mem_req=1.
  - Fetch grant: mem_we=0, mem_wdata unchanged.
- In IBUSY/DBUSY:
  - mem_req, mem_addr, mem_we and mem_wdata are held constant until mem_ack.
  - When mem_ack=1 in cycle N: the granted port's ready =1 combinationally in cycle N, and its rdata = mem_rdata in cycle N.
  - At the edge ending cycle N: mem_req←0, mem_we←0, state←IDLE.
- Latency: request first seen in IDLE at cycle 0 → mem_req=1 from cycle 1 → earliest ready in cycle 1.
  - Back-to-back transactions always pass through one IDLE cycle. Minimum period is 2 cycles per access.
- starve_cnt, updated only on a grant:
  - Data grant with ireq=1: increment, saturating at STARVE_MAX.
  - Fetch grant, or data grant with ireq=0: clear to 0.
- Stores complete on mem_ack like loads; dready pulses and drdata is don't-care.
- Requesters must hold req, address and data stable until ready.
  - The arbiter uses only the values registered at grant.
  - A req dropped before ready is a protocol violation. The transaction still completes and the ready pulse is still issued.
- mem_ack while IDLE is ignored: no ready pulse, no state change.
- Reset asserted mid-transaction:
  - Transaction is abandoned; mem_req=0 from the next cycle; no ready pulse.
  - A mem_ack arriving in the reset cycle or later is ignored.
- Only one ready may be high per cycle; iready and dready are never simultaneously 1.

Test Plan:
- Single fetch:
  - Stimulus: ireq=1, iaddr=0x00000040 at cycle 0; mem_ack at cycle 3 with mem_rdata=0x20080005.
  - Required: mem_req=1 with mem_addr=0x40 and mem_we=0 during cycles 1–3; iready=1 and irdata=0x20080005 in cycle 3 only; stall_i=1 in cycles 0–2.
- Simultaneous requests:
  - Stimulus: ireq=1 (0x44) and dreq=1, dwe=0, daddr=0x100 together; memory acks one cycle after mem_req rises.
  - Required: data is served first (mem_addr=0x100); after the IDLE cycle, fetch is served (mem_addr=0x44).
- Starvation, with STARVE_MAX=2:
  - Stimulus: ireq held at 1; dreq re-asserted after every dready.
  - Required: grant order is D, D, I, D, D, I; starve_cnt returns to 0 after each I grant.
- Store:
  - Stimulus: dreq=1, dwe=1, daddr=0x54, dwdata=0x00000007.
  - Required: mem_we=1, mem_addr=0x54, mem_wdata=7 held until ack; dready pulses once; mem_we=0 afterwards.
- Reset mid-operation:
  - Stimulus: assert reset in cycle 2 of a DBUSY transaction; memory acks in cycle 3.
  - Required: mem_req=0 from cycle 3; no dready; busy=0; a subsequent fetch completes normally.
- Spurious ack:
  - Stimulus: mem_ack=1 while IDLE with no requests.
  - Required: iready=dready=0; state remains IDLE.
